// File: rtl/multi_debouncer.sv
// Multi-channel debouncer: per-channel synchroniser, settle counter, registered
// stable level and single-cycle rise/fall pulses on each commit.
module multi_debouncer #(
  parameter int SIGNAL_NUM    = 4,
  parameter int COUNTER_WIDTH = 20,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SIGNAL_NUM-1:0]    signal_input,
  input  logic [COUNTER_WIDTH-1:0] settle_ticks,
  output logic [SIGNAL_NUM-1:0]    signal_output,
  output logic [SIGNAL_NUM-1:0]    rise_pulse,
  output logic [SIGNAL_NUM-1:0]    fall_pulse,
  output logic                     busy
);

  logic [SIGNAL_NUM-1:0]    sync_q [SYNC_STAGES];
  logic [SIGNAL_NUM-1:0]    stable;
  logic [SIGNAL_NUM-1:0]    differ;
  logic [SIGNAL_NUM-1:0]    commit;
  logic [COUNTER_WIDTH-1:0] cnt      [SIGNAL_NUM];
  logic [COUNTER_WIDTH:0]   cnt_next [SIGNAL_NUM];
  logic [COUNTER_WIDTH:0]   threshold;

  assign stable = sync_q[SYNC_STAGES-1];
  assign differ = stable ^ signal_output;
  assign busy   = |differ;

  // Compare is one bit wider than the counter so cnt+1 never wraps.
  always_comb begin
    threshold = (settle_ticks == '0) ? {{COUNTER_WIDTH{1'b0}}, 1'b1}
                                     : {1'b0, settle_ticks};
    for (int unsigned i = 0; i < SIGNAL_NUM; i++) begin
      cnt_next[i] = {1'b0, cnt[i]} + {{COUNTER_WIDTH{1'b0}}, 1'b1};
      commit[i]   = differ[i] && (cnt_next[i] >= threshold);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= signal_input;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      signal_output <= '0;
      rise_pulse    <= '0;
      fall_pulse    <= '0;
      for (int unsigned i = 0; i < SIGNAL_NUM; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < SIGNAL_NUM; i++) begin
        rise_pulse[i] <= commit[i] & stable[i];
        fall_pulse[i] <= commit[i] & ~stable[i];
        if (commit[i]) begin
          signal_output[i] <= stable[i];
          cnt[i]           <= '0;
        end else if (differ[i]) begin
          cnt[i] <= cnt_next[i][COUNTER_WIDTH-1:0];
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Self-checking bench for multi_debouncer: directed vector table, hand-written
// corner sequences and randomized pins checked against a history-based model.
module tb_multi_debouncer;
  localparam int N  = 4;
  localparam int CW = 20;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  pin;
  logic [CW-1:0] settle;
  logic [N-1:0]  signal_output, rise_pulse, fall_pulse;
  logic          busy;

  int checks = 0;
  int errors = 0;

  multi_debouncer #(.SIGNAL_NUM(N), .COUNTER_WIDTH(CW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .signal_input(pin), .settle_ticks(settle),
    .signal_output(signal_output), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: pin history per edge; the synchronised level at edge n is the pin
  // sampled SS edges earlier, and a channel commits once the trailing run of
  // disagreeing synchronised samples since its last commit reaches T.
  logic [N-1:0] pq[$];
  logic [N-1:0] sq[$];
  int           last_commit [N];
  int           n;
  logic [N-1:0] mout, mrise, mfall;
  logic         mbusy;

  function automatic logic [N-1:0] pin_at(int idx);
    return (idx >= 0) ? pq[idx] : '0;
  endfunction

  task automatic model_reset();
    pq.delete(); sq.delete();
    n = 0; mout = '0; mrise = '0; mfall = '0; mbusy = 1'b0;
    for (int c = 0; c < N; c++) last_commit[c] = -1;
  endtask

  task automatic model_edge();
    logic [N-1:0] sp, spost, past;
    int t, d;
    t = (settle == '0) ? 1 : int'(settle);
    pq.push_back(pin);
    sp = pin_at(n - SS);
    sq.push_back(sp);
    mrise = '0; mfall = '0;
    for (int c = 0; c < N; c++) begin
      if (sp[c] != mout[c]) begin
        d = 0;
        for (int m = n; m > last_commit[c]; m--) begin
          past = sq[m];
          if (past[c] != mout[c]) d++;
          else break;
        end
        if (d >= t) begin
          mout[c] = sp[c]; mrise[c] = sp[c]; mfall[c] = ~sp[c];
          last_commit[c] = n;
        end
      end
    end
    spost = pin_at(n + 1 - SS);
    mbusy = |(spost ^ mout);
    n++;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model_out",  32'(signal_output), 32'(mout));
    check("model_rise", 32'(rise_pulse),    32'(mrise));
    check("model_fall", 32'(fall_pulse),    32'(mfall));
    check("model_busy", 32'(busy),          32'(mbusy));
  endtask

  typedef struct {
    logic [N-1:0]  pin;
    logic [CW-1:0] settle;
    logic [N-1:0]  out, rise, fall;
    logic          busy;
  } vec_t;

  function automatic vec_t mk(logic p, int st, logic o, logic r, logic f, logic b);
    vec_t v;
    v.pin = {3'b000, p}; v.settle = CW'(st);
    v.out = {3'b000, o}; v.rise = {3'b000, r}; v.fall = {3'b000, f}; v.busy = b;
    return v;
  endfunction

  vec_t tbl [23];

  initial begin
    // ch0 rise with T=5, 4-cycle low glitch, fall with T=1, rise with T=0
    tbl[0]  = mk(1, 5, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) tbl[i] = mk(1, 5, 0, 0, 0, 1);
    tbl[6]  = mk(1, 5, 1, 1, 0, 0);
    tbl[7]  = mk(1, 5, 1, 0, 0, 0);
    tbl[8]  = mk(0, 5, 1, 0, 0, 0);
    tbl[9]  = mk(0, 5, 1, 0, 0, 1);
    tbl[10] = mk(0, 5, 1, 0, 0, 1);
    tbl[11] = mk(0, 5, 1, 0, 0, 1);
    tbl[12] = mk(1, 5, 1, 0, 0, 1);
    tbl[13] = mk(1, 5, 1, 0, 0, 0);
    tbl[14] = mk(1, 5, 1, 0, 0, 0);
    tbl[15] = mk(0, 1, 1, 0, 0, 0);
    tbl[16] = mk(0, 1, 1, 0, 0, 1);
    tbl[17] = mk(0, 1, 0, 0, 1, 0);
    tbl[18] = mk(0, 1, 0, 0, 0, 0);
    tbl[19] = mk(1, 0, 0, 0, 0, 0);
    tbl[20] = mk(1, 0, 0, 0, 0, 1);
    tbl[21] = mk(1, 0, 1, 1, 0, 0);
    tbl[22] = mk(1, 0, 1, 0, 0, 0);

    rst = 1'b0; pin = '0; settle = CW'(5);
    model_reset();
    #23;
    check("reset_out",  32'(signal_output), 32'h0);
    check("reset_rise", 32'(rise_pulse),    32'h0);
    check("reset_fall", 32'(fall_pulse),    32'h0);
    check("reset_busy", 32'(busy),          32'h0);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 23; i++) begin
      pin = tbl[i].pin; settle = tbl[i].settle;
      tick();
      check($sformatf("tbl%0d_out", i),  32'(signal_output), 32'(tbl[i].out));
      check($sformatf("tbl%0d_rise", i), 32'(rise_pulse),    32'(tbl[i].rise));
      check($sformatf("tbl%0d_fall", i), 32'(fall_pulse),    32'(tbl[i].fall));
      check($sformatf("tbl%0d_busy", i), 32'(busy),          32'(tbl[i].busy));
    end

    // settle_ticks lowered from 10 to 2 while cnt=5: commit on the next edge
    pin = '0; settle = CW'(10);
    for (int j = 0; j <= 6; j++) begin
      tick();
      check("lower_hold_out", 32'(signal_output[0]), 32'h1);
    end
    settle = CW'(2);
    tick();
    check("lower_commit_out",  32'(signal_output[0]), 32'h0);
    check("lower_commit_fall", 32'(fall_pulse),       32'h1);
    tick();
    check("lower_fall_clear",  32'(fall_pulse),       32'h0);
    tick(); tick();

    // independent channels: ch0 at cycle 0, ch2 at cycle 3
    settle = CW'(5);
    for (int i = 0; i < 12; i++) begin
      pin = {1'b0, (i >= 3), 1'b0, 1'b1};
      tick();
      check("multi_rise", 32'(rise_pulse),
            (i == 6) ? 32'h1 : (i == 9) ? 32'h4 : 32'h0);
      check("multi_fall", 32'(fall_pulse), 32'h0);
    end
    for (int i = 0; i < 8; i++) begin
      pin = 4'b0100;
      tick();
      check("multi_fall0", 32'(fall_pulse), (i == 6) ? 32'h1 : 32'h0);
      check("multi_rise0", 32'(rise_pulse), 32'h0);
    end
    check("multi_out", 32'(signal_output), 32'h4);

    // randomized bouncing pins with occasional settle_ticks changes
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(7) == 0) pin[c] = ~pin[c];
      if ($urandom_range(63) == 0) settle = CW'($urandom_range(6));
      tick();
    end

    // asynchronous reset in the middle of a 1->0 count
    pin = '1; settle = CW'(1);
    for (int i = 0; i < 6; i++) tick();
    check("pre_reset_out", 32'(signal_output), 32'hF);
    pin = '0; settle = CW'(10);
    for (int i = 0; i < 5; i++) tick();
    #2 rst = 1'b0;
    #1;
    check("async_out",  32'(signal_output), 32'h0);
    check("async_rise", 32'(rise_pulse),    32'h0);
    check("async_fall", 32'(fall_pulse),    32'h0);
    check("async_busy", 32'(busy),          32'h0);
    model_reset();
    @(negedge clk); @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("post_reset_nofall", 32'(fall_pulse),    32'h0);
      check("post_reset_out",    32'(signal_output), 32'h0);
    end
    pin = 4'b0001;
    for (int i = 0; i < 14; i++) begin
      tick();
      check("post_reset_rise", 32'(rise_pulse), (i == SS - 1 + 10) ? 32'h1 : 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_debouncer.md
# multi_debouncer

Multi-channel, parametrised debouncer for mechanical inputs (push-buttons, switches) feeding the board-level control logic. Each channel has its own synchroniser, its own settle counter and its own registered stable output, so channels commit independently. Adds run-time programmable settle time and single-cycle rise/fall event pulses. Downstream logic uses the pulses directly instead of building its own edge detectors.

## Interface
- SIGNAL_NUM, 4, number of independent channels (>=1)
- COUNTER_WIDTH, 20, settle counter width per channel
- SYNC_STAGES, 2, synchroniser depth per channel (>=2)
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- signal_input  input  SIGNAL_NUM  raw asynchronous pin levels
- settle_ticks  input  COUNTER_WIDTH  required consecutive stable cycles; quasi-static, read every cycle; 0 treated as 1
- signal_output  output  SIGNAL_NUM  debounced level per channel (registered)
- rise_pulse  output  SIGNAL_NUM  one-cycle pulse when signal_output[i] goes 0->1 (registered)
- fall_pulse  output  SIGNAL_NUM  one-cycle pulse when signal_output[i] goes 1->0 (registered)
- busy  output  1  OR over channels of (sync[i] != signal_output[i])

## Operation
- Per channel i: sync chain of SYNC_STAGES flops; last stage is s[i]. cnt[i] is a COUNTER_WIDTH-bit counter; out[i] drives signal_output[i].
- Let T = (settle_ticks == 0) ? 1 : settle_ticks.
- If s[i] == out[i]: cnt[i] <= 0; out unchanged; pulses 0.
- If s[i] != out[i] and cnt[i]+1 >= T: out[i] <= s[i]; cnt[i] <= 0; rise_pulse[i] <= s[i]; fall_pulse[i] <= ~s[i].
- Otherwise, if s[i] != out[i]: cnt[i] <= cnt[i]+1; pulses 0.
- Compare uses the (COUNTER_WIDTH+1)-bit value cnt+1, so there is no wrap. cnt never exceeds T-1 while T is constant.
- Disagreement that ends before T consecutive cycles (glitch/bounce) clears cnt; no output change, no pulse.
- settle_ticks lowered mid-count below cnt+1: commit on the next disagreement cycle. Raised: counting continues toward the new T.
- Channels are fully independent. Simultaneous commits on several channels are allowed, and each pulses in the same cycle.
- rise_pulse and fall_pulse are never both high on one channel. Each is high for exactly one cycle per commit.
- busy is combinational from registered state only; it has no path from signal_input.

## Timing
- Reset (rst=0, asynchronous): sync chains, cnt, signal_output, rise_pulse and fall_pulse all go to 0 immediately. busy goes to 0 because all state is 0.
- Reset mid-count aborts the count; nothing is retained.
- After rst release with a pin held high, the channel commits 1 and fires rise_pulse (power-on event is reported).
- Latency: a pin change that is stable and sampled at edge k appears on s at edge k+SYNC_STAGES-1. signal_output changes, and the pulse asserts, at edge k+SYNC_STAGES-1+T.
- Total pin-to-output delay is SYNC_STAGES+T-1 to SYNC_STAGES+T cycles, depending on sample phase.
- Pulse coincides with the signal_output edge and deasserts one cycle later unless a new commit occurs.
- Minimum spacing between two commits on a channel is T cycles.

## Test plan
- SYNC_STAGES=2, settle_ticks=5: pin 0->1 held -> signal_output[0]=1 exactly 6 edges after first sampling edge; rise_pulse[0] high 1 cycle at that edge; busy high for the 5 intervening cycles.
- settle_ticks=5: pin high for 4 cycles then low -> signal_output stays 0, no pulses, cnt returns to 0, busy drops when s returns to 0.
- SIGNAL_NUM=4: ch0 0->1 at cycle 0, ch2 0->1 at cycle 3, ch1 static -> ch0 commits at cycle 6, ch2 at cycle 9, ch1/ch3 never pulse. Then ch0 1->0 -> fall_pulse[0] only.
- settle_ticks=0 and =1: pin change -> commit after SYNC_STAGES+1 edges in both cases; identical waveforms.
- settle_ticks=10, pin toggled, at cnt=5 settle_ticks set to 2 -> commit on next edge; pulse once.
- Count in progress (cnt=3, output 1 going to 0): rst=0 asynchronously -> all outputs 0 without a clock edge. After release with pin low, no fall_pulse. With pin high, rise_pulse fires after SYNC_STAGES+T edges.
